// File: rtl/imem_dual_responder_pkg.sv
// Shared definitions for the dual-fetch instruction memory responder.
// Holds the fill word, the FSM state encodings and the index-width helper.
package imem_dual_responder_pkg;

  // ADDI x0,x0,0: used for the power-up fill and for every rejected fetch slot
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000013;

  typedef logic [0:0] state_t;
  localparam state_t ST_FILL  = 1'b0;
  localparam state_t ST_READY = 1'b1;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_2r1w_array.sv
// Instruction word storage: two registered read ports, one write port.
// Reads sample the array before a same-edge write lands (read-before-write); read data holds when re=0.
module imem_2r1w_array #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr0,
  input  logic [IW-1:0] raddr1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata0 <= mem[raddr0];
      rdata1 <= mem[raddr1];
    end
  end

endmodule

// File: rtl/imem_dual_responder.sv
// Dual-slot instruction fetch responder with program-load port and NOP fill after reset.
// Fetch response arrives 1 cycle after acceptance; no stalls once ready, fetch/load refused during fill.
module imem_dual_responder
  import imem_dual_responder_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr0,
  input  logic [31:0] fetch_addr1,
  output logic        fetch_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data0,
  output logic [31:0] rsp_data1,
  output logic [1:0]  rsp_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        init_done
);

  localparam int            IW       = idx_width(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_t        state;
  logic [IW-1:0] fill_cnt;
  logic          fetch_acc;
  logic          ld_acc;
  logic [1:0]    slot_ok;
  logic [1:0]    use_nop;
  logic          we;
  logic [IW-1:0] waddr;
  logic [31:0]   wdata;
  logic [31:0]   rd0;
  logic [31:0]   rd1;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (IW + 2)) == 32'd0);
  endfunction

  assign fetch_ready = (state == ST_READY);
  assign ld_ready    = (state == ST_READY);
  assign init_done   = (state == ST_READY);

  // Gating with reset discards any fetch or load presented in the reset cycle
  assign fetch_acc = reset && fetch_valid && fetch_ready;
  assign ld_acc    = reset && ld_valid && ld_ready && addr_ok(ld_addr);
  assign slot_ok   = {addr_ok(fetch_addr1), addr_ok(fetch_addr0)};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
    end else if (state == ST_FILL) begin
      fill_cnt <= fill_cnt + 1'b1;
      if (fill_cnt == LAST_IDX) begin
        state <= ST_READY;
      end
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = fill_cnt;
    wdata = NOP_WORD;
    if (reset) begin
      if (state == ST_FILL) begin
        we = 1'b1;
      end else if (ld_acc) begin
        we    = 1'b1;
        waddr = ld_addr[IW+1:2];
        wdata = ld_data;
      end
    end
  end

  imem_2r1w_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (fetch_acc),
    .raddr0 (fetch_addr0[IW+1:2]),
    .raddr1 (fetch_addr1[IW+1:2]),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  // use_nop is separate from rsp_err so that reset shows NOP data with no error flagged
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 2'b00;
      use_nop   <= 2'b11;
    end else if (fetch_acc) begin
      rsp_valid <= 1'b1;
      rsp_err   <= ~slot_ok;
      use_nop   <= ~slot_ok;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_data0 = use_nop[0] ? NOP_WORD : rd0;
  assign rsp_data1 = use_nop[1] ? NOP_WORD : rd1;

endmodule

// File: tb/tb_imem_dual_responder.sv
// Directed self-checking bench for imem_dual_responder: vector table plus fill/reset/burst sequences.
module tb_imem_dual_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr0;
  logic [31:0] fetch_addr1;
  logic        fetch_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data0;
  logic [31:0] rsp_data1;
  logic [1:0]  rsp_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  imem_dual_responder dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_addr0 (fetch_addr0),
    .fetch_addr1 (fetch_addr1),
    .fetch_ready (fetch_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data0   (rsp_data0),
    .rsp_data1   (rsp_data1),
    .rsp_err     (rsp_err),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld_v;
    logic [31:0] ld_a;
    logic [31:0] ld_d;
    logic        f_v;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        e_v;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0;
    fetch_addr0 = 32'd0;
    fetch_addr1 = 32'd0;
    ld_valid    = 1'b0;
    ld_addr     = 32'd0;
    ld_data     = 32'd0;
  endtask

  // Counts edges until init_done; rsp_valid must stay low while filling
  task automatic wait_init(input string name);
    int n;
    logic saw_valid;
    n = 0;
    saw_valid = 1'b0;
    while (!init_done && n < 400) begin
      step();
      n++;
      if (rsp_valid && !init_done) saw_valid = 1'b1;
    end
    fetch_valid = 1'b0;
    ld_valid    = 1'b0;
    check({name, "_fill_cycles"}, n, 256);
    check({name, "_rsp_valid_in_fill"}, {31'd0, saw_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0,   32'h00A00093, 1'b0, 32'h0, 32'h0, 1'b0, NOP, NOP, 2'b00};
    vecs[1]  = '{1'b1, 32'h4,   32'h01400113, 1'b0, 32'h0, 32'h0, 1'b0, NOP, NOP, 2'b00};
    vecs[2]  = '{1'b0, 32'h0,   32'h0, 1'b1, 32'h0, 32'h4, 1'b1, 32'h00A00093, 32'h01400113, 2'b00};
    vecs[3]  = '{1'b0, 32'h0,   32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h00A00093, 32'h01400113, 2'b00};
    vecs[4]  = '{1'b1, 32'h8,   32'h00208F33, 1'b1, 32'h8, 32'h400, 1'b1, NOP, NOP, 2'b10};
    vecs[5]  = '{1'b0, 32'h0,   32'h0, 1'b1, 32'h8, 32'h400, 1'b1, 32'h00208F33, NOP, 2'b10};
    vecs[6]  = '{1'b0, 32'h0,   32'h0, 1'b1, 32'h2, 32'h4, 1'b1, NOP, 32'h01400113, 2'b01};
    vecs[7]  = '{1'b0, 32'h0,   32'h0, 1'b1, 32'h4, 32'h4, 1'b1, 32'h01400113, 32'h01400113, 2'b00};
    vecs[8]  = '{1'b1, 32'h5,   32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 32'h01400113, 32'h01400113, 2'b00};
    vecs[9]  = '{1'b1, 32'h404, 32'hDEADBEEF, 1'b1, 32'h4, 32'h404, 1'b1, 32'h01400113, NOP, 2'b10};
    vecs[10] = '{1'b0, 32'h0,   32'h0, 1'b1, 32'h4, 32'hFFFFFFFC, 1'b1, 32'h01400113, NOP, 2'b10};
    vecs[11] = '{1'b0, 32'h0,   32'h0, 1'b1, 32'hFFFFFFFC, 32'h3, 1'b1, NOP, NOP, 2'b11};
    vecs[12] = '{1'b0, 32'h0,   32'h0, 1'b1, 32'h1000, 32'h8, 1'b1, NOP, 32'h00208F33, 2'b01};

    // Reset with fetch and load presented; both must be ignored
    idle_inputs();
    reset = 1'b0;
    fetch_valid = 1'b1;
    ld_valid = 1'b1;
    ld_data = 32'hDEADBEEF;
    step();
    step();
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data0", rsp_data0, NOP);
    check("rst_rsp_data1", rsp_data1, NOP);
    check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    check("rst_ready_flags", {29'd0, init_done, fetch_ready, ld_ready}, 32'd0);

    reset = 1'b1;
    wait_init("fill1");
    check("ready_flags", {29'd0, init_done, fetch_ready, ld_ready}, 32'd7);
    check("post_fill_data0", rsp_data0, NOP);

    for (int i = 0; i < 13; i++) begin
      ld_valid    = vecs[i].ld_v;
      ld_addr     = vecs[i].ld_a;
      ld_data     = vecs[i].ld_d;
      fetch_valid = vecs[i].f_v;
      fetch_addr0 = vecs[i].a0;
      fetch_addr1 = vecs[i].a1;
      step();
      check($sformatf("vec%0d_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].e_v});
      check($sformatf("vec%0d_data0", i), rsp_data0, vecs[i].e_d0);
      check($sformatf("vec%0d_data1", i), rsp_data1, vecs[i].e_d1);
      check($sformatf("vec%0d_err", i), {30'd0, rsp_err}, {30'd0, vecs[i].e_err});
    end
    idle_inputs();

    // Load 22 words, then 11 back-to-back dual fetches
    for (int i = 0; i < 22; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 32'(i * 4);
      ld_data  = 32'hA5000000 | 32'(i);
      step();
    end
    idle_inputs();
    for (int k = 0; k < 11; k++) begin
      fetch_valid = 1'b1;
      fetch_addr0 = 32'(k * 8);
      fetch_addr1 = 32'(k * 8 + 4);
      step();
      check($sformatf("burst%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("burst%0d_data0", k), rsp_data0, 32'hA5000000 | 32'(2 * k));
      check($sformatf("burst%0d_data1", k), rsp_data1, 32'hA5000000 | 32'(2 * k + 1));
      check($sformatf("burst%0d_err", k), {30'd0, rsp_err}, 32'd0);
    end
    idle_inputs();
    step();
    check("burst_end_valid", {31'd0, rsp_valid}, 32'd0);
    check("burst_end_hold1", rsp_data1, 32'hA5000015);

    // Reset during operation with a fetch in flight
    fetch_valid = 1'b1;
    fetch_addr0 = 32'h0;
    fetch_addr1 = 32'h4;
    reset = 1'b0;
    step();
    check("rst2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst2_rsp_data0", rsp_data0, NOP);
    check("rst2_init_done", {31'd0, init_done}, 32'd0);
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("midfill_init_done", {31'd0, init_done}, 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_init("fill2");

    fetch_valid = 1'b1;
    fetch_addr0 = 32'h0;
    fetch_addr1 = 32'h54;
    step();
    fetch_valid = 1'b0;
    check("refill_valid", {31'd0, rsp_valid}, 32'd1);
    check("refill_data0", rsp_data0, NOP);
    check("refill_data1", rsp_data1, NOP);
    check("refill_err", {30'd0, rsp_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_dual_responder.md
IMEM_DUAL_RESPONDER -- requirements
Module: imem_dual_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit instruction words, power of two.
REQ-002 Parameter NOP_WORD, default 32'h00000013: fill and out-of-range response word (ADDI x0,x0,0).
REQ-003 clk  input  1  clock; reset reset, synchronous, active-low; clock clk.
REQ-004 reset  input  1  synchronous active-low reset.
REQ-005 fetch_valid  input  1  dual-fetch request strobe from core.
REQ-006 fetch_addr0 / fetch_addr1  input  32 each  byte addresses of slot 0 / slot 1.
REQ-007 fetch_ready  output  1  responder can accept a fetch this cycle.
REQ-008 rsp_valid  output  1  response words valid.
REQ-009 rsp_data0 / rsp_data1  output  32 each  instruction words for slot 0 / slot 1.
REQ-010 rsp_err  output  2  per-slot error: bit0 slot 0, bit1 slot 1 (misaligned or out of range).
REQ-011 ld_valid  input  1  program-load write strobe.
REQ-012 ld_addr  input  32  load byte address.
REQ-013 ld_data  input  32  load word.
REQ-014 ld_ready  output  1  load write accepted this cycle.
REQ-015 init_done  output  1  high once fill is complete.

Function
REQ-016 FSM states FILL, READY; reset enters FILL with fill counter = 0.
REQ-017 In FILL, one word per cycle is written with NOP_WORD at the counter index; counter increments; FILL -> READY in the cycle the counter reaches DEPTH-1 (fill takes exactly DEPTH cycles).
REQ-018 In FILL, fetch_ready=0, ld_ready=0, init_done=0; fetch_valid and ld_valid are ignored.
REQ-019 In READY, fetch_ready=1, ld_ready=1, init_done=1.
REQ-020 Word index = addr[log2(DEPTH)+1:2].
REQ-021 A slot is in range when addr bits above log2(DEPTH)+1 are zero; it is aligned when addr[1:0]=0.
REQ-022 Fetch accepted when fetch_valid and fetch_ready; response is registered with exactly 1-cycle latency: rsp_valid=1 the next cycle, otherwise rsp_valid=0.
REQ-023 Per slot, an aligned in-range address returns the stored word with rsp_err bit=0; any other address returns NOP_WORD with rsp_err bit=1.
REQ-024 Both slots are served every accepted cycle, including identical addresses; there is no bank conflict and no stall.
REQ-025 rsp_data0/1 and rsp_err hold their last values while rsp_valid=0.
REQ-026 Load accepted when ld_valid and ld_ready; the write takes effect at that clock edge.
REQ-027 A misaligned or out-of-range load is dropped silently; ld_ready still pulses.
REQ-028 Simultaneous load and fetch of the same index in one cycle: the fetch returns the old word (read-before-write); a fetch in the next cycle returns the new word.
REQ-029 Back-to-back fetches every cycle sustain 2 words/cycle throughput.

Reset
REQ-030 On reset low at a clock edge: state=FILL, counter=0, rsp_valid=0, rsp_data0=rsp_data1=NOP_WORD, rsp_err=0, init_done=0, fetch_ready=0, ld_ready=0.
REQ-031 Reset asserted mid-fill or mid-operation restarts the full fill; previously loaded contents are overwritten with NOP_WORD.
REQ-032 Any fetch or load in flight in the reset cycle is discarded; no response is produced.

Structure
REQ-033 NOP_WORD, the index-width function, and the FILL/READY state enum belong in the shared core package.
REQ-034 The storage array is one sub-module, imem_2r1w_array: two registered read ports and one write port with read-before-write semantics.
REQ-035 The FSM, range checks and response registers reside in imem_dual_responder.

Verification
REQ-036 Release reset, hold fetch_valid=1 -> init_done rises after exactly 256 cycles; rsp_valid=0 throughout FILL.
REQ-037 After fill, load idx0=32'h00A00093 and idx1=32'h01400113, then fetch addr0=0, addr1=4 -> next cycle rsp_data0=32'h00A00093, rsp_data1=32'h01400113, rsp_err=0.
REQ-038 Fetch addr0=8, addr1=32'h00000400 -> rsp_data0=stored word, rsp_data1=32'h00000013, rsp_err=2'b10; fetch addr0=2 -> rsp_err bit0=1.
REQ-039 In one cycle, load 32'h00208F33 at address 8 and fetch addr0=8 -> old word (32'h00000013) returned; fetch again next cycle -> 32'h00208F33.
REQ-040 Load 22 words, fetch pairs (0,4),(8,12)…(80,84) on consecutive cycles -> 11 consecutive rsp_valid cycles with matching data.
REQ-041 Assert reset for one cycle at fill count 100 -> fill restarts; init_done rises 256 cycles after release; earlier loads read back as 32'h00000013.
